uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side byte FIFO of the UART, sitting between the host register interface and the transmitter state machine.
- The host pushes bytes. The transmitter reads the head byte combinationally and pops it one cycle later.
- Reports occupancy, which the transmitter uses to leave idle, and reports a sticky overrun flag for the line status register.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- FIFO_DEPTH, 16, number of entries.
- FIFO_POINTER_W, 4, read/write pointer width; equals log2(FIFO_DEPTH).
- FIFO_COUNTER_W, 5, occupancy counter width; must hold 0..FIFO_DEPTH.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- data_in, input, FIFO_WIDTH, byte to be written on push.
- data_out, output, FIFO_WIDTH, head-of-queue byte (combinational read at the read pointer).
- push, input, 1, write request, one word per cycle while high.
- pop, input, 1, read/advance request, one word per cycle while high.
- overrun, output, 1, sticky flag: a push was attempted while full.
- count, output, FIFO_COUNTER_W, current occupancy, 0..FIFO_DEPTH.
- fifo_reset, input, 1, synchronous flush of the queue.
- reset_status, input, 1, synchronous clear of overrun only.

Behaviour:
- Reset and flush:
  - rst=1: write pointer, read pointer, count and overrun all go to 0 at the next edge.
  - fifo_reset=1 (rst=0): pointers and count go to 0 and overrun is cleared. It takes priority over push/pop in that cycle.
  - Memory contents are not cleared. data_out after reset or flush is don't-care until the first push.
- Storage:
  - Circular buffer of FIFO_DEPTH words.
  - Pointers wrap from FIFO_DEPTH-1 to 0 (natural FIFO_POINTER_W-bit overflow).
- Read path:
  - data_out = mem[rd_ptr] combinationally, no read latency.
  - The head word is valid whenever count>0. The consumer samples data_out, then asserts pop.
- Per-cycle operation (rst=0, fifo_reset=0):
  - push only, count<FIFO_DEPTH: mem[wr_ptr]<=data_in; wr_ptr+1; count+1.
  - push only, count==FIFO_DEPTH: no write, pointers and count unchanged, overrun<=1.
  - pop only, count>0: rd_ptr+1; count-1.
  - pop only, count==0: ignored; no underflow, count stays 0.
  - push and pop, count>0: write at wr_ptr and advance both pointers; count unchanged; no overrun even when full.
  - push and pop, count==0: treated as push only; count becomes 1.
  - neither: hold.
- Overrun flag:
  - Sticky once set.
  - Cleared by rst, by fifo_reset, or by reset_status=1.
  - If reset_status and a full-FIFO push occur in the same cycle, set wins (overrun=1).
- count is registered and always equals the number of valid entries.
- data_out changes only when rd_ptr advances, or when a write lands at rd_ptr's location while the FIFO is empty.

Test Plan:
- Reset then idle: assert rst 1 cycle -> count=0, overrun=0; pop with empty FIFO -> count stays 0.
- Push 0xA5, then 0x3C on consecutive cycles -> count=2, data_out=0xA5. Pop 1 cycle -> data_out=0x3C, count=1. Pop again -> count=0.
- Fill with 16 bytes 0x00..0x0F -> count=16, overrun=0. 17th push of 0xFF -> overrun=1, count=16. Drain all 16 -> data_out sequence 0x00..0x0F (0xFF never appears).
- Wrap-around: push 10, pop 10, push 12 (values 0x40..0x4B) -> count=12; popping yields 0x40..0x4B in order across the pointer wrap.
- Simultaneous push+pop:
  - count=3 -> count stays 3, order preserved.
  - count=16 -> count stays 16, overrun stays 0.
  - count=0 -> count becomes 1, data_out equals the pushed byte.
- Status clears:
  - With overrun=1: reset_status=1 -> overrun=0, count unchanged.
  - Refill to overrun, then fifo_reset=1 -> count=0, overrun=0.
  - reset_status together with a full push -> overrun=1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO for the UART.
// The host pushes bytes and the transmitter reads the head word combinationally.
// Occupancy is reported on count, and a sticky overrun flag is kept for the
// line status register.
module uart_tx_fifo #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_POINTER_W = 4,
  parameter int FIFO_COUNTER_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  output logic [FIFO_WIDTH-1:0]     data_out,
  input  logic                      push,
  input  logic                      pop,
  output logic                      overrun,
  output logic [FIFO_COUNTER_W-1:0] count,
  input  logic                      fifo_reset,
  input  logic                      reset_status
);

  localparam logic [FIFO_COUNTER_W-1:0] CNT_FULL = FIFO_COUNTER_W'(FIFO_DEPTH);
  localparam logic [FIFO_COUNTER_W-1:0] CNT_ONE  = FIFO_COUNTER_W'(1);
  localparam logic [FIFO_COUNTER_W-1:0] CNT_ZERO = '0;
  localparam logic [FIFO_POINTER_W-1:0] PTR_ONE  = FIFO_POINTER_W'(1);
  localparam logic [FIFO_POINTER_W-1:0] PTR_ZERO = '0;

  // Storage is never reset; only the control state below is.
  logic [FIFO_WIDTH-1:0]     mem [0:FIFO_DEPTH-1];

  logic [FIFO_POINTER_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_POINTER_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_COUNTER_W-1:0] count_q, count_d;
  logic                      overrun_q, overrun_d;

  logic full;
  logic empty;
  logic do_pop;
  logic do_push;
  logic overrun_set;
  logic wr_en;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == CNT_ZERO);

  // A pop on an empty queue is dropped. A push on a full queue only lands
  // when a pop frees the head slot in the same cycle.
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !pop;

  // A flush suppresses the write as well as the pointer updates.
  assign wr_en = do_push && !rst && !fifo_reset;

  assign data_out = mem[rd_ptr_q];
  assign count    = count_q;
  assign overrun  = overrun_q;

  // Next-state logic for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (fifo_reset) begin
      wr_ptr_d  = PTR_ZERO;
      rd_ptr_d  = PTR_ZERO;
      count_d   = CNT_ZERO;
      overrun_d = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Setting the flag takes precedence over a status clear in the same cycle.
      if (overrun_set) begin
        overrun_d = 1'b1;
      end else if (reset_status) begin
        overrun_d = 1'b0;
      end
    end
  end

  // Control state registers with a synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Write port of the circular buffer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       push;
  logic       pop;
  logic       overrun;
  logic [4:0] count;
  logic       fifo_reset;
  logic       reset_status;

  int chk_cnt;
  int pass_cnt;

  uart_tx_fifo #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(16),
    .FIFO_POINTER_W(4),
    .FIFO_COUNTER_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_out(data_out),
    .push(push),
    .pop(pop),
    .overrun(overrun),
    .count(count),
    .fifo_reset(fifo_reset),
    .reset_status(reset_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push         = 1'b0;
    pop          = 1'b0;
    fifo_reset   = 1'b0;
    reset_status = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in = b;
    push    = 1'b1;
    step();
    push    = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun got %0b exp 0", overrun);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL empty_pop_count got %0d exp 0", count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    push_byte(8'hA5);
    push_byte(8'h3C);
    chk_cnt++;
    if (count !== 5'd2) $display("FAIL basic_count2 got %0d exp 2", count);
    else pass_cnt++;
    chk_cnt++;
    if (data_out !== 8'hA5) $display("FAIL basic_head got %h exp a5", data_out);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if (data_out !== 8'h3C) $display("FAIL basic_head2 got %h exp 3c", data_out);
    else pass_cnt++;
    chk_cnt++;
    if (count !== 5'd1) $display("FAIL basic_count1 got %0d exp 1", count);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL basic_count0 got %0d exp 0", count);
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk_cnt++;
    if (count !== 5'd16) $display("FAIL full_count got %0d exp 16", count);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL full_no_overrun got %0b exp 0", overrun);
    else pass_cnt++;
    push_byte(8'hFF);
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL full_overrun got %0b exp 1", overrun);
    else pass_cnt++;
    chk_cnt++;
    if (count !== 5'd16) $display("FAIL full_count_after_ovr got %0d exp 16", count);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if (data_out !== 8'(i)) $display("FAIL full_drain[%0d] got %h exp %h", i, data_out, 8'(i));
      else pass_cnt++;
      pop_one();
    end
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL full_drained got %0d exp 0", count);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky got %0b exp 1", overrun);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) pop_one();
    for (int i = 0; i < 12; i++) push_byte(8'h40 + 8'(i));
    chk_cnt++;
    if (count !== 5'd12) $display("FAIL wrap_count got %0d exp 12", count);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      chk_cnt++;
      if (data_out !== 8'h40 + 8'(i)) $display("FAIL wrap_data[%0d] got %h exp %h", i, data_out, 8'h40 + 8'(i));
      else pass_cnt++;
      pop_one();
    end
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL wrap_drained got %0d exp 0", count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    data_in = 8'h64;
    push    = 1'b1;
    pop     = 1'b1;
    step();
    push    = 1'b0;
    pop     = 1'b0;
    chk_cnt++;
    if (count !== 5'd3) $display("FAIL pp3_count got %0d exp 3", count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (data_out !== 8'h62 + 8'(i)) $display("FAIL pp3_order[%0d] got %h exp %h", i, data_out, 8'h62 + 8'(i));
      else pass_cnt++;
      pop_one();
    end
    data_in = 8'h77;
    push    = 1'b1;
    pop     = 1'b1;
    step();
    push    = 1'b0;
    pop     = 1'b0;
    chk_cnt++;
    if (count !== 5'd1) $display("FAIL pp0_count got %0d exp 1", count);
    else pass_cnt++;
    chk_cnt++;
    if (data_out !== 8'h77) $display("FAIL pp0_data got %h exp 77", data_out);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_status();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    chk_cnt++;
    if (overrun !== 1'b0 || count !== 5'd0)
      $display("FAIL flush_initial got cnt=%0d ovr=%0b exp cnt=0 ovr=0", count, overrun);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    data_in = 8'h90;
    push    = 1'b1;
    pop     = 1'b1;
    step();
    push    = 1'b0;
    pop     = 1'b0;
    chk_cnt++;
    if (count !== 5'd16) $display("FAIL pp16_count got %0d exp 16", count);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL pp16_overrun got %0b exp 0", overrun);
    else pass_cnt++;
    chk_cnt++;
    if (data_out !== 8'h81) $display("FAIL pp16_head got %h exp 81", data_out);
    else pass_cnt++;
    push_byte(8'h91);
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL status_set got %0b exp 1", overrun);
    else pass_cnt++;
    reset_status = 1'b1;
    step();
    reset_status = 1'b0;
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL status_clear got %0b exp 0", overrun);
    else pass_cnt++;
    chk_cnt++;
    if (count !== 5'd16) $display("FAIL status_clear_count got %0d exp 16", count);
    else pass_cnt++;
    data_in      = 8'h92;
    push         = 1'b1;
    reset_status = 1'b1;
    step();
    push         = 1'b0;
    reset_status = 1'b0;
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL set_beats_clear got %0b exp 1", overrun);
    else pass_cnt++;
    chk_cnt++;
    if (data_out !== 8'h81) $display("FAIL full_push_no_write got %h exp 81", data_out);
    else pass_cnt++;
    fifo_reset = 1'b1;
    push       = 1'b1;
    data_in    = 8'h55;
    step();
    fifo_reset = 1'b0;
    push       = 1'b0;
    chk_cnt++;
    if (count !== 5'd0) $display("FAIL flush_count got %0d exp 0", count);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL flush_overrun got %0b exp 0", overrun);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt      = 0;
    pass_cnt     = 0;
    data_in      = 8'h00;
    idle_inputs();
    rst          = 1'b1;
    step();
    step();
    rst          = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_back_to_back();
    test_status();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
